// File: rtl/rtl_settings_pkg.sv
// Shared settings and types for the test sequencer: address/burst geometry,
// test and address modes, sequencer states, register field positions, LFSR taps.
package rtl_settings_pkg;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned AMM_BURST_W = 11;
  localparam int unsigned DATA_B_W    = 16;
  localparam int unsigned BURST_W     = AMM_BURST_W - 1;

  // Register 1 field positions
  localparam int unsigned TEST_MODE_LSB = 16;
  localparam int unsigned ADDR_MODE_LSB = 18;
  localparam int unsigned FIELD_W       = 2;

  // Fibonacci LFSR taps for x^32 + x^22 + x^2 + x + 1 (bits 31, 21, 1, 0)
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic {
    AT_WORD = 1'b0,
    AT_BYTE = 1'b1
  } addr_type_t;

  localparam addr_type_t ADDR_TYPE = AT_WORD;

  typedef enum logic [1:0] {
    TM_WRITE_ONLY      = 2'd0,
    TM_READ_ONLY       = 2'd1,
    TM_WRITE_AND_CHECK = 2'd2
  } test_mode_t;

  typedef enum logic [1:0] {
    AM_FIX = 2'd0,
    AM_RUN = 2'd1,
    AM_RND = 2'd2
  } addr_mode_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_GAP   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } seq_state_t;

  // Raw mode field to test mode; the reserved encoding runs as write-only
  function automatic test_mode_t decode_test_mode(input logic [1:0] f);
    case (f)
      2'd1:    return TM_READ_ONLY;
      2'd2:    return TM_WRITE_AND_CHECK;
      default: return TM_WRITE_ONLY;
    endcase
  endfunction

  // Raw address-mode field to address mode; the reserved encoding is fixed
  function automatic addr_mode_t decode_addr_mode(input logic [1:0] f);
    case (f)
      2'd1:    return AM_RUN;
      2'd2:    return AM_RND;
      default: return AM_FIX;
    endcase
  endfunction

  // One LFSR step: shift left, feedback is XOR of the tapped bits
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/test_sequencer_addr_gen.sv
// Address generator for the test sequencer: fixed, running (stepped, wrapping)
// or LFSR-random addresses. load_i restarts from base, advance_i moves to the next.
module test_sequencer_addr_gen
  import rtl_settings_pkg::*;
#(
  parameter logic [31:0] RND_SEED = 32'hACE1_1234
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               advance_i,
  input  addr_mode_t         addr_mode_i,
  input  logic [BURST_W-1:0] burst_i,
  input  logic [ADDR_W-1:0]  base_i,
  output logic [ADDR_W-1:0]  addr_o
);

  addr_mode_t        mode_q;
  logic [ADDR_W-1:0] step_q;
  logic [ADDR_W-1:0] step_c;
  logic [ADDR_W-1:0] step_word_c;
  logic [31:0]       lfsr_q;
  logic [31:0]       lfsr_next_c;

  // Step size from burst length, scaled to bytes for byte-addressed buses
  always_comb begin
    step_word_c = ADDR_W'(burst_i) + ADDR_W'(1);
    step_c      = step_word_c;
    if (ADDR_TYPE == AT_BYTE) begin
      step_c = step_word_c * ADDR_W'(DATA_B_W);
    end
    lfsr_next_c = lfsr_step(lfsr_q);
  end

  // Address / LFSR state; RUN wraps modulo 2^ADDR_W naturally
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mode_q <= AM_FIX;
      step_q <= '0;
      lfsr_q <= RND_SEED;
      addr_o <= '0;
    end else if (load_i) begin
      mode_q <= addr_mode_i;
      step_q <= step_c;
      lfsr_q <= RND_SEED;
      addr_o <= base_i;
    end else if (advance_i) begin
      case (mode_q)
        AM_RUN: addr_o <= addr_o + step_q;
        AM_RND: begin
          lfsr_q <= lfsr_next_c;
          addr_o <= lfsr_next_c[ADDR_W-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/test_sequencer.sv
// Test-level controller for transmitter_block: on start_test_i issues a
// sequence of single-cycle transaction requests, spaced by transmitter busy,
// counts them, aborts on compare error and reports completion.
// Optional build macro TEST_SEQ_PAUSE_EN adds pause_i, which holds off issuing.
module test_sequencer
  import rtl_settings_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter logic [31:0] RND_SEED = 32'hACE1_1234
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_test_i,
  input  logic [4:1][31:0]  test_param_reg_i,
  input  logic              trans_block_busy_i,
  input  logic              error_check_i,
`ifdef TEST_SEQ_PAUSE_EN
  input  logic              pause_i,
`endif
  output logic              trans_valid_o,
  output logic [ADDR_W-1:0] trans_addr_o,
  output logic              trans_type_o,
  output logic              test_running_o,
  output logic              test_done_o,
  output logic              test_error_o,
  output logic [CNT_W-1:0]  trans_cnt_o
);

  seq_state_t        state_q;
  seq_state_t        state_next;
  test_mode_t        mode_q;
  logic [CNT_W-1:0]  total_q;
  logic              phase_q;   // WRITE_AND_CHECK: 0 = write next, 1 = read-back next
  logic              last_q;    // final op of the test has been issued

  logic              start_c;
  logic              issue_c;
  logic              err_c;
  logic              advance_c;
  logic              type_c;
  logic              last_c;
  logic              pause_c;
  logic [ADDR_W-1:0] addr_cur;
  logic              unused_bits;

`ifdef TEST_SEQ_PAUSE_EN
  assign pause_c = pause_i;
`else
  assign pause_c = 1'b0;
`endif

  // Register bits that carry no field for this block
  assign unused_bits = ^{test_param_reg_i[2], test_param_reg_i[1][31:20],
                         test_param_reg_i[1][15:BURST_W]};

  test_sequencer_addr_gen #(
    .RND_SEED (RND_SEED)
  ) u_addr_gen (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (start_c),
    .advance_i   (advance_c),
    .addr_mode_i (decode_addr_mode(test_param_reg_i[1][ADDR_MODE_LSB +: FIELD_W])),
    .burst_i     (test_param_reg_i[1][BURST_W-1:0]),
    .base_i      (test_param_reg_i[4][ADDR_W-1:0]),
    .addr_o      (addr_cur)
  );

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_c) begin
          state_next = (test_param_reg_i[3] == 32'd0) ? S_DRAIN : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (err_c) begin
          state_next = S_DRAIN;
        end else if (issue_c) begin
          state_next = S_GAP;
        end
      end
      S_GAP: begin
        state_next = (err_c || last_q) ? S_DRAIN : S_ISSUE;
      end
      S_DRAIN: begin
        if (!trans_block_busy_i) begin
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Per-cycle strobes: accept start, issue one op, record error, op type, address advance
  always_comb begin
    start_c   = 1'b0;
    issue_c   = 1'b0;
    err_c     = 1'b0;
    type_c    = 1'b0;
    advance_c = 1'b0;
    last_c    = 1'b0;
    start_c   = (state_q == S_IDLE) && start_test_i;
    err_c     = error_check_i &&
                ((state_q == S_ISSUE) || (state_q == S_GAP) || (state_q == S_DRAIN));
    issue_c   = (state_q == S_ISSUE) && !trans_block_busy_i && !error_check_i && !pause_c;
    case (mode_q)
      TM_READ_ONLY:       type_c = 1'b1;
      TM_WRITE_AND_CHECK: type_c = phase_q;
      default:            type_c = 1'b0;
    endcase
    // Move to the next address only once every op for the current one is out
    advance_c = issue_c && ((mode_q != TM_WRITE_AND_CHECK) || phase_q);
    last_c    = (trans_cnt_o + CNT_W'(1)) == total_q;
  end

  // Test parameters latched at start, op phase and last-op tracking
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mode_q  <= TM_WRITE_ONLY;
      total_q <= '0;
      phase_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (start_c) begin
      mode_q  <= decode_test_mode(test_param_reg_i[1][TEST_MODE_LSB +: FIELD_W]);
      total_q <= CNT_W'(test_param_reg_i[3]);
      phase_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (issue_c) begin
      phase_q <= (mode_q == TM_WRITE_AND_CHECK) ? ~phase_q : 1'b0;
      last_q  <= last_c;
    end
  end

  // Registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      trans_valid_o  <= 1'b0;
      trans_addr_o   <= '0;
      trans_type_o   <= 1'b0;
      test_running_o <= 1'b0;
      test_done_o    <= 1'b0;
      test_error_o   <= 1'b0;
      trans_cnt_o    <= '0;
    end else begin
      trans_valid_o  <= issue_c;
      test_running_o <= (state_next != S_IDLE);
      test_done_o    <= (state_next == S_DONE);
      if (issue_c) begin
        trans_addr_o <= addr_cur;
        trans_type_o <= type_c;
      end
      if (start_c) begin
        test_error_o <= 1'b0;
      end else if (err_c) begin
        test_error_o <= 1'b1;
      end
      if (start_c) begin
        trans_cnt_o <= '0;
      end else if (issue_c) begin
        trans_cnt_o <= trans_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_test_sequencer.sv
// Scoreboard bench for test_sequencer: expected transactions are queued when a
// test is started; a monitor pops and compares on every trans_valid_o.
module tb_test_sequencer;

  typedef struct packed {
    logic [31:0] addr;
    logic        typ;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             start_test_i = 1'b0;
  logic [4:1][31:0] regs = '0;
  logic             busy;
  logic             error_check_i = 1'b0;
  logic             pause_i = 1'b0;
  logic             trans_valid_o;
  logic [31:0]      trans_addr_o;
  logic             trans_type_o;
  logic             test_running_o;
  logic             test_done_o;
  logic             test_error_o;
  logic [31:0]      trans_cnt_o;

  logic             busy_force = 1'b0;
  int unsigned      bcnt;
  int unsigned      busy_len = 2;
  logic             busy_seen;
  logic             valid_seen;
  exp_t             exp_q[$];
  exp_t             e;
  int               n_checks = 0;
  int               n_fail = 0;

  always #5 clk = ~clk;

  test_sequencer dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .start_test_i       (start_test_i),
    .test_param_reg_i   (regs),
    .trans_block_busy_i (busy),
    .error_check_i      (error_check_i),
`ifdef TEST_SEQ_PAUSE_EN
    .pause_i            (pause_i),
`endif
    .trans_valid_o      (trans_valid_o),
    .trans_addr_o       (trans_addr_o),
    .trans_type_o       (trans_type_o),
    .test_running_o     (test_running_o),
    .test_done_o        (test_done_o),
    .test_error_o       (test_error_o),
    .trans_cnt_o        (trans_cnt_o)
  );

  // Transmitter model: busy for busy_len cycles after each accepted request
  always @(posedge clk) begin
    if (rst_i) bcnt <= 0;
    else if (trans_valid_o) bcnt <= busy_len;
    else if (bcnt != 0) bcnt <= bcnt - 1;
  end
  assign busy = busy_force || (bcnt != 0);

  // What the DUT saw on the edge that produced the current outputs
  always @(posedge clk) begin
    busy_seen  <= busy;
    valid_seen <= trans_valid_o;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every request against the scoreboard
  always @(negedge clk) begin
    if (!rst_i && trans_valid_o) begin
      chk("no_back_to_back", valid_seen, 1'b0);
      chk("no_issue_while_busy", busy_seen, 1'b0);
      if (exp_q.size() == 0) begin
        chk("unexpected_valid_addr", trans_addr_o, 64'hDEAD);
      end else begin
        e = exp_q.pop_front();
        chk("trans_addr", trans_addr_o, e.addr);
        chk("trans_type", trans_type_o, e.typ);
      end
    end
  end

  function automatic logic [31:0] mk_r1(input int tm, input int am, input int burst);
    return (32'(am) << 18) | (32'(tm) << 16) | 32'(burst);
  endfunction

  function automatic logic [31:0] lfsr_adv(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  task automatic push(input logic [31:0] a, input logic t);
    exp_t x;
    x.addr = a;
    x.typ  = t;
    exp_q.push_back(x);
  endtask

  task automatic start_test(input logic [31:0] r1, input logic [31:0] r3, input logic [31:0] r4);
    @(negedge clk);
    regs[1] = r1;
    regs[2] = 32'h0;
    regs[3] = r3;
    regs[4] = r4;
    start_test_i = 1'b1;
    @(negedge clk);
    start_test_i = 1'b0;
    chk("running_after_start", test_running_o, 1'b1);
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (!test_done_o && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    chk("done_seen", test_done_o, 1'b1);
  endtask

  task automatic finish_test(input logic [31:0] exp_cnt, input logic exp_err);
    int cyc;
    wait_done(2000, cyc);
    chk("trans_cnt", trans_cnt_o, exp_cnt);
    chk("test_error", test_error_o, exp_err);
    @(negedge clk);
    chk("done_one_cycle", test_done_o, 1'b0);
    chk("running_cleared", test_running_o, 1'b0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int          cyc;
    int          nv;
    logic [31:0] s1;
    logic [31:0] s2;

    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    chk("rst_valid", trans_valid_o, 1'b0);
    chk("rst_addr", trans_addr_o, 32'h0);
    chk("rst_type", trans_type_o, 1'b0);
    chk("rst_running", test_running_o, 1'b0);
    chk("rst_done", test_done_o, 1'b0);
    chk("rst_error", test_error_o, 1'b0);
    chk("rst_cnt", trans_cnt_o, 32'h0);

    // Error pulse while idle is ignored
    error_check_i = 1'b1;
    @(negedge clk);
    error_check_i = 1'b0;
    @(negedge clk);
    chk("idle_error_ignored", test_error_o, 1'b0);

    // WRITE_ONLY, RUN, burst 3 (step 4 words)
    push(32'h100, 1'b0); push(32'h104, 1'b0); push(32'h108, 1'b0); push(32'h10C, 1'b0);
    start_test(mk_r1(0, 1, 3), 32'd4, 32'h100);
    finish_test(32'd4, 1'b0);

    // WRITE_AND_CHECK, FIX; a second start mid-test must be ignored
    for (int i = 0; i < 3; i++) begin
      push(32'h40, 1'b0);
      push(32'h40, 1'b1);
    end
    start_test(mk_r1(2, 0, 0), 32'd6, 32'h40);
    repeat (4) @(negedge clk);
    regs[1] = mk_r1(1, 1, 7);
    regs[3] = 32'd1;
    regs[4] = 32'h999;
    start_test_i = 1'b1;
    @(negedge clk);
    start_test_i = 1'b0;
    finish_test(32'd6, 1'b0);

    // RUN wraps at the top of the address space
    push(32'hFFFF_FFFC, 1'b0); push(32'h0, 1'b0); push(32'h4, 1'b0);
    start_test(mk_r1(0, 1, 3), 32'd3, 32'hFFFF_FFFC);
    finish_test(32'd3, 1'b0);

    // Error after the 3rd request of 10 aborts the test
    push(32'h20, 1'b0); push(32'h20, 1'b0); push(32'h20, 1'b0);
    start_test(mk_r1(0, 0, 0), 32'd10, 32'h20);
    nv = 0;
    cyc = 0;
    while (nv < 3 && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (trans_valid_o) nv++;
    end
    chk("error_test_three_valids", 64'(nv), 64'd3);
    error_check_i = 1'b1;
    @(negedge clk);
    error_check_i = 1'b0;
    finish_test(32'd3, 1'b1);

    // READ_ONLY, RND: base first, then successive LFSR states
    s1 = lfsr_adv(32'hACE1_1234);
    s2 = lfsr_adv(s1);
    push(32'h1000, 1'b1); push(s1, 1'b1); push(s2, 1'b1);
    start_test(mk_r1(1, 2, 0), 32'd3, 32'h1000);
    finish_test(32'd3, 1'b0);

    // Odd total in WRITE_AND_CHECK ends after a write; mode 3 runs as write-only
    push(32'h200, 1'b0); push(32'h200, 1'b1); push(32'h208, 1'b0);
    start_test(mk_r1(2, 1, 7), 32'd3, 32'h200);
    finish_test(32'd3, 1'b0);
    push(32'h300, 1'b0); push(32'h300, 1'b0);
    start_test(mk_r1(3, 3, 1), 32'd2, 32'h300);
    finish_test(32'd2, 1'b0);

    // Busy held high: nothing issued until it drops
    busy_force = 1'b1;
    push(32'h80, 1'b0); push(32'h80, 1'b0);
    start_test(mk_r1(0, 0, 0), 32'd2, 32'h80);
    nv = 0;
    repeat (20) begin
      @(negedge clk);
      if (trans_valid_o) nv++;
    end
    chk("busy_hold_no_valid", 64'(nv), 64'd0);
    busy_force = 1'b0;
    finish_test(32'd2, 1'b0);

    // total = 0: no request, done within 3 cycles
    start_test(mk_r1(0, 0, 0), 32'd0, 32'h0);
    wait_done(3, cyc);
    chk("zero_total_cnt", trans_cnt_o, 32'd0);
    @(negedge clk);
    chk("zero_total_scoreboard", 64'(exp_q.size()), 64'd0);

`ifdef TEST_SEQ_PAUSE_EN
    // Pause freezes issuing; test resumes when released
    pause_i = 1'b1;
    push(32'h500, 1'b0); push(32'h500, 1'b0);
    start_test(mk_r1(0, 0, 0), 32'd2, 32'h500);
    nv = 0;
    repeat (10) begin
      @(negedge clk);
      if (trans_valid_o) nv++;
    end
    chk("pause_no_valid", 64'(nv), 64'd0);
    chk("pause_still_running", test_running_o, 1'b1);
    pause_i = 1'b0;
    finish_test(32'd2, 1'b0);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
